// File: rtl/fruit_miss_counter_if.sv
// Signal bundle between the fruit engine (master) and the miss counter (slave).
// The counter publishes miss_num to the life/heart display logic.
interface fruit_miss_counter_if #(
   parameter int unsigned NF       = 6,
   parameter int unsigned MAX_MISS = 255
);
   localparam int unsigned MissW = $clog2(MAX_MISS + 1);

   logic             Initialize;
   logic             frame_clk_rising_edge;
   logic             game_over;
   logic [NF-1:0]    fruit_active;
   logic [NF-1:0]    fruit_sliced;
   logic [NF*10-1:0] fruit_y;
   logic [MissW-1:0] miss_num;
   logic             miss_pulse;

   modport master (
      output Initialize, frame_clk_rising_edge, game_over,
      output fruit_active, fruit_sliced, fruit_y,
      input  miss_num, miss_pulse
   );

   modport slave (
      input  Initialize, frame_clk_rising_edge, game_over,
      input  fruit_active, fruit_sliced, fruit_y,
      output miss_num, miss_pulse
   );
endinterface

// File: rtl/fruit_miss_counter.sv
// Counts unsliced fruits crossing MISS_Y and publishes a frame-stable, saturating miss count.
// Misses accumulate in pend between frame edges and flush into miss_num on each edge.
module fruit_miss_counter #(
   parameter int unsigned NF       = 6,
   parameter logic [9:0]  MISS_Y   = 10'd470,
   parameter int unsigned MAX_MISS = 255
) (
   input logic            Clk,
   input logic            Reset_n,
   fruit_miss_counter_if.slave bus
);
   localparam int unsigned CntW  = $clog2(NF + 1);
   localparam int unsigned MissW = $clog2(MAX_MISS + 1);
   localparam int unsigned PendW = MissW + 1;
   localparam int unsigned SumW  = PendW + 1;
   localparam logic [SumW-1:0] MaxSum = SumW'(MAX_MISS);

   logic [NF-1:0]    hit;
   logic [NF-1:0]    counted_q, counted_d;
   logic [CntW-1:0]  new_cnt;
   logic [PendW-1:0] pend_q, pend_d;
   logic [MissW-1:0] miss_num_q, miss_num_d;
   logic             miss_pulse_q, miss_pulse_d;
   logic [SumW-1:0]  pend_sum, miss_sum;

   always_comb begin
      hit     = '0;
      new_cnt = '0;
      for (int i = 0; i < NF; i++) begin
         hit[i] = bus.fruit_active[i] & ~bus.fruit_sliced[i] &
                  (bus.fruit_y[10*i +: 10] >= MISS_Y) & ~counted_q[i] & ~bus.game_over;
         new_cnt = new_cnt + CntW'(hit[i]);
      end
   end

   always_comb begin
      pend_sum     = SumW'(pend_q) + SumW'(new_cnt);
      // Edge-cycle hits join this update directly so they are neither lost nor doubled.
      miss_sum     = SumW'(miss_num_q) + pend_sum;
      counted_d    = counted_q;
      pend_d       = pend_q;
      miss_num_d   = miss_num_q;
      miss_pulse_d = 1'b0;
      if (bus.Initialize) begin
         // Fruits already past the line at game start must not be recounted.
         counted_d  = bus.fruit_active;
         pend_d     = '0;
         miss_num_d = '0;
      end else begin
         counted_d = (counted_q | hit) & bus.fruit_active;
         if (bus.frame_clk_rising_edge) begin
            miss_num_d   = (miss_sum > MaxSum) ? MissW'(MAX_MISS) : miss_sum[MissW-1:0];
            miss_pulse_d = (miss_num_d > miss_num_q);
            pend_d       = '0;
         end else begin
            pend_d = (pend_sum > MaxSum) ? PendW'(MAX_MISS) : pend_sum[PendW-1:0];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         counted_q    <= '0;
         pend_q       <= '0;
         miss_num_q   <= '0;
         miss_pulse_q <= 1'b0;
      end else begin
         counted_q    <= counted_d;
         pend_q       <= pend_d;
         miss_num_q   <= miss_num_d;
         miss_pulse_q <= miss_pulse_d;
      end
   end

   assign bus.miss_num   = miss_num_q;
   assign bus.miss_pulse = miss_pulse_q;
endmodule
